// File: rtl/emulib_rammodel_sched_pkg.sv
// Shared definitions for the RAM-model completion scheduler: entry layout and FSM states.
// An entry is packed as {write, id, len, due} with the due timestamp in the LSBs.
package emulib_rammodel_sched_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WRB  = 2'd2,
    ST_RD   = 2'd3
  } sched_state_e;

  function automatic int entry_width(input int id_w, input int cnt_w);
    return 1 + id_w + LEN_W + cnt_w;
  endfunction

  function automatic int len_lsb(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic int id_lsb(input int cnt_w);
    return cnt_w + LEN_W;
  endfunction

  function automatic int wr_bit(input int id_w, input int cnt_w);
    return cnt_w + LEN_W + id_w;
  endfunction

endpackage

// File: rtl/emulib_rammodel_sched_queue.sv
// In-order request queue with fall-through head; also exposes the entry behind the head
// so the scheduler can launch the next command in the cycle right after a pop.
module emulib_rammodel_sched_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data,
  output logic [WIDTH-1:0]         next_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign head_data = mem_r[rd_ptr_r];
  assign next_data = mem_r[rd_ptr_r + AW'(1)];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/emulib_rammodel_sched.sv
// Fixed-latency completion scheduler: queues tracker requests with a due timestamp and
// retires them in acceptance order as B commands (writes) or R beat commands (reads).
module emulib_rammodel_sched
  import emulib_rammodel_sched_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int R_LATENCY    = 16,
  parameter int W_LATENCY    = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          areq_valid,
  input  logic                          areq_write,
  input  logic [ID_WIDTH-1:0]           areq_id,
  input  logic [7:0]                    areq_len,
  input  logic                          wreq_valid,
  input  logic                          wreq_last,
  output logic                          bcmd_valid,
  input  logic                          bcmd_ready,
  output logic [ID_WIDTH-1:0]           bcmd_id,
  output logic                          rcmd_valid,
  input  logic                          rcmd_ready,
  output logic [ID_WIDTH-1:0]           rcmd_id,
  output logic                          rcmd_last,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          overflow
);

  localparam int OCC_W   = $clog2(MAX_INFLIGHT) + 1;
  localparam int ENTRY_W = entry_width(ID_WIDTH, CNT_WIDTH);
  localparam int LEN_LSB = len_lsb(CNT_WIDTH);
  localparam int ID_LSB  = id_lsb(CNT_WIDTH);
  localparam int WR_BIT  = wr_bit(ID_WIDTH, CNT_WIDTH);

  // Ripe once now has reached due, using the sign of the wrapped difference
  function automatic logic is_ripe(input logic [CNT_WIDTH-1:0] t, input logic [CNT_WIDTH-1:0] due);
    logic [CNT_WIDTH-1:0] diff;
    diff = t - due;
    return ~diff[CNT_WIDTH-1];
  endfunction

  sched_state_e         state_r;
  logic [CNT_WIDTH-1:0] now_r;
  logic [CNT_WIDTH-1:0] now_nxt_s;
  logic [CNT_WIDTH-1:0] due_s;
  logic [ENTRY_W-1:0]   entry_s;
  logic [ENTRY_W-1:0]   head_s;
  logic [ENTRY_W-1:0]   next_s;
  logic [ENTRY_W-1:0]   cand_s;
  logic                 cand_avail_s;
  logic                 cand_write_s;
  logic [ID_WIDTH-1:0]  cand_id_s;
  logic [7:0]           cand_len_s;
  logic [CNT_WIDTH-1:0] cand_due_s;
  logic [7:0]           head_len_s;
  logic                 q_full_s;
  logic                 q_empty_s;
  logic [OCC_W-1:0]     q_count_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 wr_inc_s;
  logic                 wr_dec_s;
  logic [OCC_W-1:0]     wdone_r;
  logic [OCC_W-1:0]     wdone_nxt_s;
  logic                 go_s;
  logic                 launch_s;
  logic                 more_s;
  logic                 overflow_r;
  logic                 bcmd_valid_r;
  logic [ID_WIDTH-1:0]  bcmd_id_r;
  logic                 rcmd_valid_r;
  logic [ID_WIDTH-1:0]  rcmd_id_r;
  logic                 rcmd_last_r;
  logic [7:0]           beat_r;

  assign now_nxt_s = now_r + CNT_WIDTH'(1);
  assign due_s     = now_r + (areq_write ? CNT_WIDTH'(W_LATENCY) : CNT_WIDTH'(R_LATENCY));
  assign entry_s   = {areq_write, areq_id, areq_len, due_s};
  assign push_s    = areq_valid;
  assign wr_inc_s  = wreq_valid && wreq_last;
  assign wr_dec_s  = (state_r == ST_WRB) && bcmd_ready;
  assign pop_s     = wr_dec_s || ((state_r == ST_RD) && rcmd_ready && rcmd_last_r);
  assign more_s    = (q_count_s > OCC_W'(1)) || push_s;

  emulib_rammodel_sched_queue #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (entry_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s),
    .head_data (head_s),
    .next_data (next_s)
  );

  // Write-burst completion count as it will stand after this edge
  always_comb begin
    wdone_nxt_s = wdone_r;
    case ({wr_inc_s, wr_dec_s})
      2'b10:   wdone_nxt_s = wdone_r + OCC_W'(1);
      2'b01:   wdone_nxt_s = wdone_r - OCC_W'(1);
      default: wdone_nxt_s = wdone_r;
    endcase
  end

  // Launch candidate: the head while waiting, the entry behind it when retiring the head
  always_comb begin
    cand_s       = next_s;
    cand_avail_s = 1'b0;
    if (state_r == ST_WAIT) begin
      cand_s       = head_s;
      cand_avail_s = !q_empty_s;
    end else begin
      cand_s       = next_s;
      cand_avail_s = (q_count_s > OCC_W'(1));
    end
  end

  assign cand_write_s = cand_s[WR_BIT];
  assign cand_id_s    = cand_s[WR_BIT-1:ID_LSB];
  assign cand_len_s   = cand_s[ID_LSB-1:LEN_LSB];
  assign cand_due_s   = cand_s[LEN_LSB-1:0];
  assign head_len_s   = head_s[ID_LSB-1:LEN_LSB];
  // Ripeness is judged against the next timestamp because valid is registered
  assign go_s     = cand_avail_s && is_ripe(now_nxt_s, cand_due_s) &&
                    (!cand_write_s || (wdone_nxt_s != {OCC_W{1'b0}}));
  assign launch_s = go_s && ((state_r == ST_WAIT) || pop_s);

  // Timestamp, write-completion count and sticky overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      now_r      <= {CNT_WIDTH{1'b0}};
      wdone_r    <= {OCC_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      now_r      <= now_nxt_s;
      wdone_r    <= wdone_nxt_s;
      overflow_r <= overflow_r || (push_s && q_full_s && !pop_s);
    end
  end

  // Retirement FSM with registered command outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      bcmd_valid_r <= 1'b0;
      bcmd_id_r    <= {ID_WIDTH{1'b0}};
      rcmd_valid_r <= 1'b0;
      rcmd_id_r    <= {ID_WIDTH{1'b0}};
      rcmd_last_r  <= 1'b0;
      beat_r       <= 8'd0;
    end else if (launch_s) begin
      if (cand_write_s) begin
        state_r      <= ST_WRB;
        bcmd_valid_r <= 1'b1;
        bcmd_id_r    <= cand_id_s;
        rcmd_valid_r <= 1'b0;
        rcmd_last_r  <= 1'b0;
      end else begin
        state_r      <= ST_RD;
        bcmd_valid_r <= 1'b0;
        rcmd_valid_r <= 1'b1;
        rcmd_id_r    <= cand_id_s;
        rcmd_last_r  <= (cand_len_s == 8'd0);
        beat_r       <= 8'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!q_empty_s) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (q_empty_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WRB: begin
          if (bcmd_ready) begin
            bcmd_valid_r <= 1'b0;
            state_r      <= more_s ? ST_WAIT : ST_IDLE;
          end else begin
            state_r <= ST_WRB;
          end
        end
        ST_RD: begin
          if (rcmd_ready && rcmd_last_r) begin
            rcmd_valid_r <= 1'b0;
            rcmd_last_r  <= 1'b0;
            state_r      <= more_s ? ST_WAIT : ST_IDLE;
          end else if (rcmd_ready) begin
            beat_r      <= beat_r + 8'd1;
            rcmd_last_r <= ((beat_r + 8'd1) == head_len_s);
          end else begin
            state_r <= ST_RD;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bcmd_valid = bcmd_valid_r;
  assign bcmd_id    = bcmd_id_r;
  assign rcmd_valid = rcmd_valid_r;
  assign rcmd_id    = rcmd_id_r;
  assign rcmd_last  = rcmd_last_r;
  assign inflight   = q_count_s;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_emulib_rammodel_sched.sv
// Directed bench for the completion scheduler: default instance plus a narrow-timestamp
// instance for the counter-wrap case. Cycle c after reset release has now == c.
module tb_emulib_rammodel_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       areq_valid = 1'b0, areq_write = 1'b0, areq_valid_w = 1'b0;
  logic [3:0] areq_id = 4'd0;
  logic [7:0] areq_len = 8'd0;
  logic       wreq_valid = 1'b0, wreq_last = 1'b0, bcmd_ready = 1'b0, rcmd_ready = 1'b0;
  logic       bcmd_valid, rcmd_valid, rcmd_last, overflow;
  logic [3:0] bcmd_id, rcmd_id, inflight;
  logic       bcmd_valid_w, rcmd_valid_w, rcmd_last_w, overflow_w;
  logic [3:0] bcmd_id_w, rcmd_id_w, inflight_w;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         retired;

  always #5 clk = ~clk;

  emulib_rammodel_sched dut (
    .clk(clk), .rstn(rstn), .areq_valid(areq_valid), .areq_write(areq_write),
    .areq_id(areq_id), .areq_len(areq_len), .wreq_valid(wreq_valid), .wreq_last(wreq_last),
    .bcmd_valid(bcmd_valid), .bcmd_ready(bcmd_ready), .bcmd_id(bcmd_id),
    .rcmd_valid(rcmd_valid), .rcmd_ready(rcmd_ready), .rcmd_id(rcmd_id),
    .rcmd_last(rcmd_last), .inflight(inflight), .overflow(overflow)
  );

  emulib_rammodel_sched #(.CNT_WIDTH(5), .R_LATENCY(12)) dut_w (
    .clk(clk), .rstn(rstn), .areq_valid(areq_valid_w), .areq_write(areq_write),
    .areq_id(areq_id), .areq_len(areq_len), .wreq_valid(1'b0), .wreq_last(1'b0),
    .bcmd_valid(bcmd_valid_w), .bcmd_ready(1'b1), .bcmd_id(bcmd_id_w),
    .rcmd_valid(rcmd_valid_w), .rcmd_ready(rcmd_ready), .rcmd_id(rcmd_id_w),
    .rcmd_last(rcmd_last_w), .inflight(inflight_w), .overflow(overflow_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    areq_valid = 1'b0; areq_valid_w = 1'b0; areq_write = 1'b0; areq_id = 4'd0; areq_len = 8'd0;
    wreq_valid = 1'b0; wreq_last = 1'b0; bcmd_ready = 1'b0; rcmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset state of both instances
    do_reset();
    check_eq("rst_bvalid", 32'(bcmd_valid), 32'd0);
    check_eq("rst_rvalid", 32'(rcmd_valid), 32'd0);
    check_eq("rst_rlast", 32'(rcmd_last), 32'd0);
    check_eq("rst_ids", 32'({bcmd_id, rcmd_id}), 32'd0);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_w_outs", 32'({bcmd_valid_w, rcmd_valid_w, rcmd_last_w, overflow_w,
                                bcmd_id_w, rcmd_id_w, inflight_w}), 32'd0);

    // Single read: id 3, len 3 at cycle 10 -> beats in cycles 26..29
    do_reset();
    rcmd_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      areq_valid = (c == 10); areq_write = 1'b0; areq_id = 4'd3; areq_len = 8'd3;
      check_eq($sformatf("t1_rvalid@%0d", c), 32'(rcmd_valid), 32'(c >= 26 && c <= 29));
      check_eq($sformatf("t1_rlast@%0d", c), 32'(rcmd_last), 32'(c == 29));
      if (c >= 26 && c <= 29) check_eq($sformatf("t1_rid@%0d", c), 32'(rcmd_id), 32'd3);
      step();
    end

    // Write with early W burst, B held off until cycle 22
    do_reset();
    for (int c = 0; c < 25; c++) begin
      wreq_valid = (c == 5); wreq_last = (c == 5);
      areq_valid = (c == 10); areq_write = 1'b1; areq_id = 4'd1; areq_len = 8'd0;
      bcmd_ready = (c >= 22);
      check_eq($sformatf("t2_bvalid@%0d", c), 32'(bcmd_valid), 32'(c >= 18 && c <= 22));
      if (c >= 18 && c <= 22) check_eq($sformatf("t2_bid@%0d", c), 32'(bcmd_id), 32'd1);
      if (c == 22) check_eq("t2_inflight_before_pop", 32'(inflight), 32'd1);
      if (c == 23) check_eq("t2_inflight_after_pop", 32'(inflight), 32'd0);
      step();
    end

    // Write with late W burst: B not before the cycle after wreq_last
    do_reset();
    bcmd_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      wreq_valid = (c == 30); wreq_last = (c == 30);
      areq_valid = (c == 10); areq_write = 1'b1; areq_id = 4'd2; areq_len = 8'd0;
      check_eq($sformatf("t3_bvalid@%0d", c), 32'(bcmd_valid), 32'(c == 31));
      step();
    end

    // Ordering: write at 0 then read at 1 -> B at 8, R at 17
    do_reset();
    bcmd_ready = 1'b1; rcmd_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      wreq_valid = (c == 0); wreq_last = (c == 0);
      areq_valid = (c <= 1); areq_write = (c == 0); areq_id = (c == 0) ? 4'd5 : 4'd6; areq_len = 8'd0;
      check_eq($sformatf("t4a_bvalid@%0d", c), 32'(bcmd_valid), 32'(c == 8));
      check_eq($sformatf("t4a_rvalid@%0d", c), 32'(rcmd_valid), 32'(c == 17));
      if (c == 8) check_eq("t4a_bid", 32'(bcmd_id), 32'd5);
      if (c == 17) check_eq("t4a_rid", 32'(rcmd_id), 32'd6);
      step();
    end

    // Ordering: read len 2 at 0 then ripe write at 1 -> B right after the last beat
    do_reset();
    bcmd_ready = 1'b1; rcmd_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      wreq_valid = (c == 1); wreq_last = (c == 1);
      areq_valid = (c <= 1); areq_write = (c == 1); areq_id = (c == 0) ? 4'd7 : 4'd8;
      areq_len = (c == 0) ? 8'd2 : 8'd0;
      check_eq($sformatf("t4b_rvalid@%0d", c), 32'(rcmd_valid), 32'(c >= 16 && c <= 18));
      check_eq($sformatf("t4b_rlast@%0d", c), 32'(rcmd_last), 32'(c == 18));
      check_eq($sformatf("t4b_bvalid@%0d", c), 32'(bcmd_valid), 32'(c == 19));
      if (c == 19) check_eq("t4b_bid", 32'(bcmd_id), 32'd8);
      step();
    end

    // Overflow: nine reads into an eight-deep queue, then drain
    do_reset();
    retired = 0;
    for (int c = 0; c < 70; c++) begin
      areq_valid = (c <= 8); areq_write = 1'b0; areq_id = 4'(c); areq_len = 8'd0;
      rcmd_ready = (c >= 20);
      if (c == 8) check_eq("t5_ovf_before", 32'(overflow), 32'd0);
      if (c == 9) begin
        check_eq("t5_ovf_set", 32'(overflow), 32'd1);
        check_eq("t5_inflight_full", 32'(inflight), 32'd8);
      end
      if (rcmd_valid && rcmd_ready && rcmd_last) begin
        check_eq($sformatf("t5_order%0d", retired), 32'(rcmd_id), 32'(retired));
        retired++;
      end
      step();
    end
    check_eq("t5_retired", 32'(retired), 32'd8);
    check_eq("t5_inflight_drained", 32'(inflight), 32'd0);
    check_eq("t5_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    check_eq("t5_ovf_reset", 32'(overflow), 32'd0);

    // Wrap: 5-bit timestamp, read at now=25 issues at now=5 (cycle 37)
    do_reset();
    rcmd_ready = 1'b1;
    for (int c = 0; c < 37; c++) begin
      areq_valid_w = (c == 25); areq_write = 1'b0; areq_id = 4'd9; areq_len = 8'd1;
      check_eq($sformatf("t6_rvalid@%0d", c), 32'(rcmd_valid_w), 32'd0);
      step();
    end
    check_eq("t6_rvalid_due", 32'(rcmd_valid_w), 32'd1);
    check_eq("t6_rid", 32'(rcmd_id_w), 32'd9);
    check_eq("t6_rlast_first", 32'(rcmd_last_w), 32'd0);
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_mid_valid", 32'(rcmd_valid_w), 32'd0);
    check_eq("t6_rst_mid_inflight", 32'(inflight_w), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 60; c++) begin
      check_eq($sformatf("t6_quiet@%0d", c), 32'(rcmd_valid_w | bcmd_valid_w), 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
